// File: rtl/adc_sample_checker.sv
// Locks onto the expected AD9643 output sequence (ramp, 4-word user pattern or constant),
// checks every captured sample against it and counts mismatches and over-range samples.
module adc_sample_checker #(
  parameter int DATA_W    = 14,
  parameter int LOCK_CNT  = 16,
  parameter int LOSS_CNT  = 4,
  parameter int ERR_CNT_W = 32,
  parameter int OR_CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [1:0]           mode,
  input  logic [DATA_W-1:0]    user_pat1,
  input  logic [DATA_W-1:0]    user_pat2,
  input  logic [DATA_W-1:0]    user_pat3,
  input  logic [DATA_W-1:0]    user_pat4,
  input  logic                 clr_cnt,
  input  logic                 sample_valid,
  input  logic [DATA_W-1:0]    sample,
  input  logic                 over_range,
  output logic                 locked,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [OR_CNT_W-1:0]  or_cnt,
  output logic [DATA_W-1:0]    expected,
  output logic [1:0]           state
);

  localparam int MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int MISS_W  = $clog2(LOSS_CNT + 1);
  localparam logic [1:0] MODE_RAMP = 2'd0;
  localparam logic [1:0] MODE_USER = 2'd1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEEK   = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           mode_q;
  logic [DATA_W-1:0]    expected_q, expected_d;
  logic [1:0]           idx_q, idx_d;
  logic                 seeded_q, seeded_d;
  logic                 reseed_q, reseed_d;
  logic [MATCH_W-1:0]   match_q, match_d;
  logic [MISS_W-1:0]    miss_q, miss_d;
  logic                 err_pulse_q, err_pulse_d;
  logic                 locked_q, locked_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [OR_CNT_W-1:0]  or_cnt_q, or_cnt_d;

  logic [DATA_W-1:0]    pat [4];
  logic                 seed_ok;
  logic [DATA_W-1:0]    seed_exp;
  logic [1:0]           seed_idx;
  logic [1:0]           hit;
  logic [DATA_W-1:0]    adv_exp;
  logic [1:0]           adv_idx;

  function automatic logic [ERR_CNT_W-1:0] sat_inc_err(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : v + ERR_CNT_W'(1);
  endfunction

  function automatic logic [OR_CNT_W-1:0] sat_inc_or(input logic [OR_CNT_W-1:0] v);
    return (&v) ? v : v + OR_CNT_W'(1);
  endfunction

  always_comb begin
    pat[0] = user_pat1;
    pat[1] = user_pat2;
    pat[2] = user_pat3;
    pat[3] = user_pat4;
  end

  // Seed = value that follows the sample; advance = value that follows expected.
  always_comb begin
    seed_ok  = 1'b1;
    hit      = 2'd0;
    seed_exp = sample + DATA_W'(1);
    seed_idx = 2'd0;
    adv_exp  = expected_q + DATA_W'(1);
    adv_idx  = 2'd0;
    if (mode == MODE_USER) begin
      if (sample == pat[0])      hit = 2'd0;
      else if (sample == pat[1]) hit = 2'd1;
      else if (sample == pat[2]) hit = 2'd2;
      else if (sample == pat[3]) hit = 2'd3;
      else                       seed_ok = 1'b0;
      seed_idx = hit + 2'd1;
      seed_exp = pat[seed_idx];
      adv_idx  = idx_q + 2'd1;
      adv_exp  = pat[adv_idx];
    end else if (mode != MODE_RAMP) begin
      seed_exp = user_pat1;
      adv_exp  = expected_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    expected_d  = expected_q;
    idx_d       = idx_q;
    seeded_d    = seeded_q;
    reseed_d    = reseed_q;
    match_d     = match_q;
    miss_d      = miss_q;
    err_pulse_d = 1'b0;
    err_cnt_d   = err_cnt_q;
    or_cnt_d    = or_cnt_q;

    if (!en) begin
      state_d = ST_IDLE;
    end else if (state_q == ST_IDLE || mode != mode_q) begin
      state_d  = ST_SEEK;
      seeded_d = 1'b0;
      reseed_d = 1'b0;
      match_d  = '0;
      miss_d   = '0;
    end else if (sample_valid) begin
      if (over_range) begin
        // ADC holds its output while over range: count it, resync on the next clean sample.
        or_cnt_d = sat_inc_or(or_cnt_q);
        reseed_d = 1'b1;
      end else if (state_q == ST_SEEK) begin
        if (!seeded_q || reseed_q || sample != expected_q) begin
          seeded_d = seed_ok;
          reseed_d = 1'b0;
          match_d  = '0;
          if (seed_ok) begin
            expected_d = seed_exp;
            idx_d      = seed_idx;
          end
        end else begin
          expected_d = adv_exp;
          idx_d      = adv_idx;
          if (match_q == MATCH_W'(LOCK_CNT - 1)) begin
            state_d = ST_LOCKED;
            match_d = '0;
            miss_d  = '0;
          end else begin
            match_d = match_q + MATCH_W'(1);
          end
        end
      end else if (reseed_q) begin
        reseed_d = 1'b0;
        seeded_d = seed_ok;
        if (seed_ok) begin
          expected_d = seed_exp;
          idx_d      = seed_idx;
        end else begin
          state_d = ST_SEEK;
          match_d = '0;
          miss_d  = '0;
        end
      end else begin
        // Locked: expected free-runs from itself so a bad sample does not derail the sequence.
        expected_d = adv_exp;
        idx_d      = adv_idx;
        if (sample != expected_q) begin
          err_pulse_d = 1'b1;
          err_cnt_d   = sat_inc_err(err_cnt_q);
          if (miss_q == MISS_W'(LOSS_CNT - 1)) begin
            state_d = ST_SEEK;
            match_d = '0;
            miss_d  = '0;
          end else begin
            miss_d = miss_q + MISS_W'(1);
          end
        end else begin
          miss_d = '0;
        end
      end
    end

    if (clr_cnt) begin
      err_cnt_d = '0;
      or_cnt_d  = '0;
    end
    locked_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mode_q      <= 2'd0;
      expected_q  <= '0;
      idx_q       <= 2'd0;
      seeded_q    <= 1'b0;
      reseed_q    <= 1'b0;
      match_q     <= '0;
      miss_q      <= '0;
      err_pulse_q <= 1'b0;
      locked_q    <= 1'b0;
      err_cnt_q   <= '0;
      or_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode;
      expected_q  <= expected_d;
      idx_q       <= idx_d;
      seeded_q    <= seeded_d;
      reseed_q    <= reseed_d;
      match_q     <= match_d;
      miss_q      <= miss_d;
      err_pulse_q <= err_pulse_d;
      locked_q    <= locked_d;
      err_cnt_q   <= err_cnt_d;
      or_cnt_q    <= or_cnt_d;
    end
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign err_cnt   = err_cnt_q;
  assign or_cnt    = or_cnt_q;
  assign expected  = expected_q;
  assign state     = state_q;

endmodule

// File: tb/tb_adc_sample_checker.sv
// Directed + randomized bench for adc_sample_checker against a sequence-phase reference model.
module tb_adc_sample_checker;

  localparam int DW     = 14;
  localparam int RAMP_M = 1 << DW;
  localparam int LOCK   = 16;
  localparam int LOSS   = 4;
  localparam int OR_MAX = 65535;

  logic          clk = 1'b0;
  logic          rst_n, en, clr_cnt, sample_valid, over_range;
  logic [1:0]    mode;
  logic [DW-1:0] user_pat1, user_pat2, user_pat3, user_pat4, sample;
  logic          locked, err_pulse;
  logic [31:0]   err_cnt;
  logic [15:0]   or_cnt;
  logic [DW-1:0] expected;
  logic [1:0]    state;

  adc_sample_checker dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
    .user_pat1(user_pat1), .user_pat2(user_pat2), .user_pat3(user_pat3), .user_pat4(user_pat4),
    .clr_cnt(clr_cnt), .sample_valid(sample_valid), .sample(sample), .over_range(over_range),
    .locked(locked), .err_pulse(err_pulse), .err_cnt(err_cnt), .or_cnt(or_cnt),
    .expected(expected), .state(state)
  );

  always #5 clk = ~clk;

  int cmp_n = 0;
  int bad_n = 0;

  // Reference model: the expected stream is seq_val(mode, phase); seeding finds the phase of a sample.
  int          m_st, m_exp, m_ph, m_match, m_miss, m_or, m_prev_mode;
  bit          m_seeded, m_reseed, m_pulse;
  logic [31:0] m_err;
  int          r_nxt;

  function automatic int pat_word(input int k);
    case (k % 4)
      0:       return int'(user_pat1);
      1:       return int'(user_pat2);
      2:       return int'(user_pat3);
      default: return int'(user_pat4);
    endcase
  endfunction

  function automatic int seq_len(input int md);
    return (md == 0) ? RAMP_M : (md == 1) ? 4 : 1;
  endfunction

  function automatic int seq_val(input int md, input int ph);
    if (md == 0) return ph;
    if (md == 1) return pat_word(ph);
    return pat_word(0);
  endfunction

  function automatic int seq_find(input int md, input int s);
    if (md == 0) return s;
    if (md == 1) begin
      for (int k = 0; k < 4; k++) if (pat_word(k) == s) return k;
      return -1;
    end
    return 0;
  endfunction

  task automatic m_seed(input int md, input int s);
    int ph;
    ph = seq_find(md, s);
    if (ph < 0) begin
      m_seeded = 1'b0;
    end else begin
      m_seeded = 1'b1;
      m_ph     = (ph + 1) % seq_len(md);
      m_exp    = seq_val(md, m_ph);
    end
  endtask

  task automatic m_clock();
    int md, s;
    bit miss;
    md = int'(mode);
    s  = int'(sample);
    if (!rst_n) begin
      m_st = 0; m_exp = 0; m_ph = 0; m_match = 0; m_miss = 0; m_or = 0; m_err = 0;
      m_seeded = 0; m_reseed = 0; m_pulse = 0; m_prev_mode = 0;
      return;
    end
    m_pulse = 0;
    if (!en) begin
      m_st = 0;
    end else if (m_st == 0 || md != m_prev_mode) begin
      m_st = 1; m_seeded = 0; m_reseed = 0; m_match = 0; m_miss = 0;
    end else if (sample_valid) begin
      if (over_range) begin
        if (m_or < OR_MAX) m_or++;
        m_reseed = 1;
      end else if (m_st == 1) begin
        if (!m_seeded || m_reseed || s != m_exp) begin
          m_seed(md, s); m_match = 0; m_reseed = 0;
        end else begin
          m_ph = (m_ph + 1) % seq_len(md); m_exp = seq_val(md, m_ph);
          m_match++;
          if (m_match == LOCK) begin m_st = 2; m_match = 0; m_miss = 0; end
        end
      end else if (m_reseed) begin
        m_reseed = 0;
        m_seed(md, s);
        if (!m_seeded) begin m_st = 1; m_match = 0; m_miss = 0; end
      end else begin
        miss = (s != m_exp);
        m_ph = (m_ph + 1) % seq_len(md); m_exp = seq_val(md, m_ph);
        if (miss) begin
          m_pulse = 1;
          if (m_err != 32'hFFFF_FFFF) m_err = m_err + 1;
          m_miss++;
          if (m_miss == LOSS) begin m_st = 1; m_miss = 0; m_match = 0; end
        end else begin
          m_miss = 0;
        end
      end
    end
    if (clr_cnt) begin m_err = 0; m_or = 0; end
    m_prev_mode = md;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    cmp_n++;
    assert (obs === expv)
      else begin
        bad_n++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
  endtask

  task automatic check_all();
    chk("state", 32'(state), m_st);
    chk("locked", 32'(locked), (m_st == 2) ? 1 : 0);
    chk("err_pulse", 32'(err_pulse), 32'(m_pulse));
    chk("err_cnt", err_cnt, m_err);
    chk("or_cnt", 32'(or_cnt), m_or);
    chk("expected", 32'(expected), m_exp);
  endtask

  task automatic step(input bit v, input int s, input bit o);
    sample_valid = v;
    sample       = DW'(s);
    over_range   = o;
    @(posedge clk);
    m_clock();
    #1;
    check_all();
  endtask

  // Ramp samples from r_nxt with occasional invalid cycles carrying junk.
  task automatic ramp_run(input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) step(0, int'($urandom_range(0, RAMP_M - 1)), 1'($urandom));
      step(1, r_nxt, 0);
      r_nxt = (r_nxt + 1) % RAMP_M;
    end
  endtask

  initial begin
    int j, pick;
    rst_n = 0; en = 0; mode = 0; clr_cnt = 0;
    user_pat1 = 0; user_pat2 = 0; user_pat3 = 0; user_pat4 = 0;
    step(0, 0, 0);
    step(1, 5, 1);
    chk("reset_state", 32'(state), 0);
    chk("reset_expected", 32'(expected), 0);

    // Full ramp with wrap.
    rst_n = 1; en = 1; mode = 0;
    step(0, 0, 0);
    chk("idle_to_seek", 32'(state), 1);
    for (int v = 0; v < RAMP_M; v++) begin
      step(1, v, 0);
      if (v == 15) chk("ramp_not_locked_15", 32'(locked), 0);
      if (v == 16) chk("ramp_locked_16", 32'(locked), 1);
    end
    for (int v = 0; v <= 16'h10; v++) step(1, v, 0);
    chk("wrap_no_err", err_cnt, 0);
    chk("wrap_locked", 32'(locked), 1);

    // Single corrupted sample.
    for (int v = 16'h11; v < 16'h100; v++) step(1, v, 0);
    step(1, 16'h1234, 0);
    chk("inject_pulse", 32'(err_pulse), 1);
    chk("inject_err_cnt", err_cnt, 1);
    chk("inject_locked", 32'(locked), 1);
    step(1, 16'h0101, 0);
    chk("inject_next_ok", 32'(err_pulse), 0);

    // Four corrupted samples drop lock; sixteen good ones regain it.
    clr_cnt = 1; step(0, 0, 0); clr_cnt = 0;
    chk("clr_err", err_cnt, 0);
    for (int i = 0; i < 4; i++) step(1, (16'h102 + i) ^ int'($urandom_range(1, RAMP_M - 1)), 0);
    chk("loss_err_cnt", err_cnt, 4);
    chk("loss_state", 32'(state), 1);
    chk("loss_unlocked", 32'(locked), 0);
    r_nxt = 16'h106;
    ramp_run(15);
    chk("relock_15", 32'(locked), 0);
    ramp_run(1);
    chk("relock_16", 32'(locked), 1);

    // Over-range burst holding full scale, then ramp resumes elsewhere.
    for (int i = 0; i < 10; i++) step(1, 16'h3FFF, 1);
    r_nxt = 5;
    ramp_run(8);
    chk("or_cnt_10", 32'(or_cnt), 10);
    chk("or_err_cnt", err_cnt, 4);
    chk("or_locked", 32'(locked), 1);

    // Clear wins over a same-cycle mismatch.
    clr_cnt = 1; step(1, r_nxt ^ 1, 0); clr_cnt = 0;
    r_nxt = (r_nxt + 1) % RAMP_M;
    chk("clr_prio_err", err_cnt, 0);
    chk("clr_prio_pulse", 32'(err_pulse), 1);

    // Disable keeps counters.
    en = 0; step(1, r_nxt, 1);
    chk("en_off_idle", 32'(state), 0);
    chk("en_off_or", 32'(or_cnt), 0);

    // User pattern cycle starting at the third word.
    user_pat1 = 14'h0AAA; user_pat2 = 14'h1555; user_pat3 = 14'h3FFF; user_pat4 = 14'h0000;
    en = 1; mode = 1; step(0, 0, 0);
    for (int i = 0; i < 20; i++) step(1, pat_word(2 + i), 0);
    chk("user_locked", 32'(locked), 1);
    chk("user_no_err", err_cnt, 0);
    step(1, pat_word(2 + 19), 0);
    chk("user_repeat_pulse", 32'(err_pulse), 1);

    // Constant pattern with a mode change straight from lock.
    user_pat1 = DW'($urandom_range(0, RAMP_M - 1));
    mode = 2; step(1, int'(user_pat1), 0);
    chk("mode_change_seek", 32'(state), 1);
    for (int i = 0; i < 18; i++) step(1, int'(user_pat1), 0);
    chk("const_locked", 32'(locked), 1);
    step(1, int'(user_pat1) ^ 3, 0);
    chk("const_pulse", 32'(err_pulse), 1);

    // Randomized soak.
    en = 0; step(0, 0, 0);
    user_pat1 = DW'($urandom); user_pat2 = DW'($urandom);
    user_pat3 = DW'($urandom); user_pat4 = DW'($urandom);
    en = 1; mode = 1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 199) == 0) mode = 2'($urandom);
      clr_cnt = ($urandom_range(0, 299) == 0);
      en = ($urandom_range(0, 499) != 0);
      pick = int'($urandom_range(0, 99));
      if (pick < 75)      j = m_exp;
      else if (pick < 85) j = pat_word(int'($urandom_range(0, 3)));
      else                j = int'($urandom_range(0, RAMP_M - 1));
      step(($urandom_range(0, 99) < 85), j, ($urandom_range(0, 99) < 5));
    end
    clr_cnt = 0; en = 1;

    // Reset while locked.
    mode = 0; r_nxt = int'($urandom_range(0, RAMP_M - 1));
    step(0, 0, 0);
    ramp_run(20);
    chk("pre_reset_locked", 32'(locked), 1);
    rst_n = 0; step(1, r_nxt, 1);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_state", 32'(state), 0);
    chk("rst_or", 32'(or_cnt), 0);
    chk("rst_expected", 32'(expected), 0);
    rst_n = 1;
    step(0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, bad_n);
    $finish;
  end

endmodule
